// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART transmitter definitions: bus address,
// serializer state encodings and default bit timing.
package uart_tx_fifo_pkg;

  localparam logic [31:0] UART_ADDR = 32'h1000_0000;

  // 100 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Byte FIFO with separately tracked occupancy count.
// Ports: clk, reset, push/push_data in; pop in;
//        pop_data (head, combinational), full, empty, count out.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       pop_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)
        count <= count + (PTR_W+1)'(1);
      else if (pop_ok && !push_ok)
        count <= count - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by CPU stores.
// Ports: clk, reset, wr_en, wr_data in; full, empty,
//   count, busy, uart_tx, overflow out. Defining
//   UART_TX_FIFO_OVF_EN makes overflow sticky on dropped
//   writes and adds the drop_cnt[7:0] output port.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH        = 16,
  parameter int PTR_W        = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [7:0]     wr_data,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count,
  output logic           busy,
  output logic           uart_tx,
  output logic           overflow
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic [7:0]     drop_cnt
`endif
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX =
    BW'(CLKS_PER_BIT - 1);

  tx_state_e     state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    head;
  logic          pop;
  logic          baud_end;

  assign pop      = (state == TX_IDLE) && !empty;
  assign baud_end = (baud == BAUD_MAX);
  assign busy     = (state != TX_IDLE);

  sync_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= TX_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      unique case (state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          if (!empty) begin
            shift   <= head;
            uart_tx <= 1'b0;
            baud    <= '0;
            state   <= TX_START;
          end
        end
        TX_START: begin
          if (baud_end) begin
            baud    <= '0;
            uart_tx <= shift[0];
            bit_idx <= '0;
            state   <= TX_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= TX_STOP;
            end else begin
              // next bit is shift[1] before the shift lands
              shift   <= shift >> 1;
              uart_tx <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_end) begin
            baud  <= '0;
            state <= TX_IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a line decoder
// compares received bytes against queued expectations.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int DEP = 4;
  localparam int PW  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          full;
  logic          empty;
  logic [PW:0]   count;
  logic          busy;
  logic          uart_tx;
  logic          overflow;
`ifdef UART_TX_FIFO_OVF_EN
  logic [7:0]    drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEP),
    .PTR_W        (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .busy     (busy),
    .uart_tx  (uart_tx),
    .overflow (overflow)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_busy_low();
    int n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    if (busy) check("busy_low_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !empty) && n < 3000) begin
      n++;
      tick();
    end
    if (busy || !empty) check("idle_timeout", 1, 0);
    tick();
    tick();
  endtask

  // Line decoder: samples each bit mid-cell on negedge.
  initial begin : monitor
    logic       prev;
    logic [7:0] rx;
    logic       abort;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && prev && !uart_tx) begin
        starts.push_back(cyc);
        abort = 1'b0;
        rx = '0;
        for (int k = 1; k <= 38; k++) begin
          @(negedge clk);
          if (reset) begin
            abort = 1'b1;
            break;
          end
          if (k == 2) check("start_bit", uart_tx, 0);
          if (k >= 6 && k <= 34 && (k % 4) == 2)
            rx[(k - 6) / 4] = uart_tx;
          if (k == 38) check("stop_bit", uart_tx, 1);
        end
        if (!abort) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_unexpected: got %0h want none",
                     rx);
          end else begin
            check("rx_byte", rx, exp_q.pop_front());
          end
        end
      end
      prev = uart_tx;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    tick();

    // single byte: frame timing and flags
    exp_q.push_back(8'hA5);
    push(8'hA5);
    check("t1_count_e0", count, 1);
    check("t1_tx_e0", uart_tx, 1);
    tick();
    check("t1_tx_e1", uart_tx, 0);
    check("t1_empty_e1", empty, 1);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check("t1_busy_cycles", n, 40);
    wait_idle();

    // burst of three: spacing and peak occupancy
    starts.delete();
    foreach (exp_q[i]) ;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    push(8'h41);
    push(8'h42);
    check("t2_count_e1", count, 1);
    push(8'h43);
    check("t2_count_peak", count, 2);
    wait_idle();
    check("t2_nframes", starts.size(), 3);
    if (starts.size() == 3) begin
      check("t2_gap1", starts[1] - starts[0], 41);
      check("t2_gap2", starts[2] - starts[1], 41);
    end

    // fill while mid-frame, fifth write dropped
    for (int i = 0; i < 5; i++)
      exp_q.push_back(8'h10 + 8'(i));
    push(8'h10);
    tick();
    for (int i = 1; i <= 4; i++) push(8'h10 + 8'(i));
    check("t3_count_full", count, 4);
    check("t3_full", full, 1);
    push(8'h15);
    check("t3_count_drop", count, 4);
    check("t3_full2", full, 1);
`ifdef UART_TX_FIFO_OVF_EN
    check("t3_ovf", overflow, 1);
    check("t3_drop_cnt", drop_cnt, 1);
`else
    check("t3_ovf_off", overflow, 0);
`endif

    // full at the pop edge: pop happens, push drops
    wait_busy_low();
    check("t4_full_idle", count, 4);
    push(8'h7E);
    check("t4_count_pop", count, 3);
    check("t4_busy", busy, 1);
`ifdef UART_TX_FIFO_OVF_EN
    check("t4_drop_cnt", drop_cnt, 2);
`endif
    wait_idle();

    // two held, push on each pop edge, pointers wrap
    for (int i = 0; i < 11; i++)
      exp_q.push_back(8'h50 + 8'(i));
    push(8'h50);
    push(8'h51);
    push(8'h52);
    check("t4_count2", count, 2);
    for (int i = 0; i < 8; i++) begin
      wait_busy_low();
      push(8'h53 + 8'(i));
      check("t4_count_hold", count, 2);
    end
    wait_idle();

    // reset mid-frame during data bit 3
    exp_q.push_back(8'h3C);
    push(8'h3C);
    push(8'h3D);
    push(8'h3E);
    check("t5_count_q", count, 2);
    repeat (16) tick();
    check("t5_busy_mid", busy, 1);
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("t5_tx", uart_tx, 1);
    check("t5_busy", busy, 0);
    check("t5_count", count, 0);
    check("t5_empty", empty, 1);
    check("t5_ovf", overflow, 0);
    reset = 1'b0;
    repeat (120) tick();
    check("t5_quiet_count", count, 0);
    check("t5_quiet_tx", uart_tx, 1);

    // ten bytes through four entries
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (full && n < 200) begin
        n++;
        tick();
      end
      exp_q.push_back(8'(i));
      push(8'(i));
    end
    wait_idle();
    check("t6_count_end", count, 0);
    check("t6_exp_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter, directly downstream of the CPU memory-access stage.
- A store to the UART address pushes one byte into a FIFO; an 8N1 serializer drains the FIFO onto the pin.
- Lets the CPU issue back-to-back UART stores without losing characters while a frame is on the line.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200). Must be >= 2.
- DEPTH, 16: FIFO entries. Must be a power of two, >= 2.
- PTR_W, 4: log2(DEPTH); used for pointer width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  push strobe: store to UART address in the memory-access stage
- wr_data  in  8  byte to push (rs2[7:0])
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- count  out  PTR_W+1  current occupancy, 0..DEPTH
- busy  out  1  serializer not in IDLE
- uart_tx  out  1  serial line, registered, idle high
- overflow  out  1  sticky drop flag (see Optional Feature)

Behaviour:
- Reset: on any edge with reset=1:
  - rd_ptr=0, wr_ptr=0, count=0, state=IDLE, bit and baud counters 0.
  - uart_tx=1, overflow=0.
  - Reset mid-frame aborts the frame; the line is high from the next edge. Buffered bytes are discarded.
- Flags: full=(count==DEPTH), empty=(count==0). Both are combinational from registered count.
- Push: if wr_en && !full, write mem[wr_ptr]=wr_data and wr_ptr+=1 (wraps mod DEPTH).
  - If wr_en && full, the byte is dropped and no state changes, even if a pop occurs the same edge.
- Pop: happens only in IDLE when !empty. Load shift register from mem[rd_ptr]; rd_ptr+=1 (wraps).
- Simultaneous push and pop in the same edge: count unchanged, both pointers advance.
- Pointer arithmetic: PTR_W bits, natural wrap. count is tracked separately, so full and empty are never ambiguous.
- FSM states are IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1 within each bit.
  - IDLE: uart_tx=1. If !empty: pop, uart_tx<=0, baud=0, go START.
  - START: hold 0 for CLKS_PER_BIT cycles, then uart_tx<=shift[0], bit=0, go DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first.
    - After bit 7: uart_tx<=1, go STOP.
    - Otherwise: shift right, bit+=1, drive the next bit.
  - STOP: hold 1 for CLKS_PER_BIT cycles, then go IDLE.
- Latency and frame timing:
  - Write sampled at edge E0 into an empty idle FIFO: uart_tx falls after edge E1.
  - Frame occupies 10*CLKS_PER_BIT cycles. One IDLE cycle follows before the next start bit.
  - Back-to-back frame period is 10*CLKS_PER_BIT+1 cycles.
- busy = (state != IDLE).

Optional Feature:
- Macro: UART_TX_FIFO_OVF_EN.
- Defined:
  - overflow is set on any edge where wr_en && full, and held until reset.
  - An internal 8-bit saturating drop counter is exposed as the extra output port drop_cnt[7:0], reset 0.
- Undefined:
  - overflow is tied 0 and the drop_cnt port does not exist.
  - Dropped writes are silent.

Decomposition:
- Shared define header, alongside the existing UART_ADDR define: FSM state encodings (TX_IDLE=2'd0, TX_START=2'd1, TX_DATA=2'd2, TX_STOP=2'd3) and the default CLKS_PER_BIT.
- One sub-module, sync_fifo: storage, pointers, count and full/empty, parameterised by DEPTH/PTR_W.
- The serializer FSM stays in the top of uart_tx_fifo.

Test Plan (CLKS_PER_BIT=4, DEPTH=4 unless noted):
- Single byte: push 0xA5 at E0 -> uart_tx low after E1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop high 4 cycles; busy high for 40 cycles; empty=1 after E1.
- Burst: push 0x41,0x42,0x43 on consecutive edges -> count peaks 2 (first popped at E1); three frames, each start bit 41 cycles after the previous; bytes decode in order.
- Full/drop: with serializer mid-frame, push 5 bytes -> count stops at 4, full=1, 5th byte never transmitted; with UART_TX_FIFO_OVF_EN, overflow=1 and drop_cnt=1.
- Simultaneous push/pop: FIFO full at the IDLE pop edge, push 0x7E same edge -> 0x7E dropped, count 4->3; FIFO holding 2 at a pop edge with push -> count stays 2, pointers wrap correctly after 8 such operations.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> next edge uart_tx=1, busy=0, count=0, empty=1; no further frames transmitted.
- Wrap: push/drain 10 bytes 0x00..0x09 through DEPTH=4 -> all transmitted in order, count returns to 0.
